// File: rtl/countdown_timer.sv
// countdown_timer: mm:ss BCD down-counter with load, start/pause/resume
// and a one-cycle done pulse when the count reaches 00:00.
module countdown_timer #(
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       start_stop,
    input  logic [3:0] init_min_tens,
    input  logic [3:0] init_min_ones,
    input  logic [3:0] init_sec_tens,
    input  logic [3:0] init_sec_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       expired
);

    localparam int CNT_W = $clog2(TICKS_PER_SEC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        PAUSED,
        EXPIRED
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] presc;
    logic             tick;
    logic             is_zero;
    logic             at_one;

    function automatic logic [3:0] clamp(input logic [3:0] d,
                                         input logic [3:0] mx);
        return (d > mx) ? mx : d;
    endfunction

    assign tick    = (state == RUNNING) && (presc == LAST);
    assign is_zero = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);
    assign at_one  = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0001);
    assign running = (state == RUNNING);
    assign expired = (state == EXPIRED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            presc    <= '0;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == RUNNING) begin
                if (start_stop)
                    state <= PAUSED;
                if (tick) begin
                    presc <= '0;
                    // 00:01 -> 00:00 expires on the same edge, overriding a pause
                    if (at_one) begin
                        state    <= EXPIRED;
                        done     <= 1'b1;
                        sec_ones <= 4'd0;
                    end else if (sec_ones != 4'd0) begin
                        sec_ones <= sec_ones - 4'd1;
                    end else begin
                        sec_ones <= 4'd9;
                        if (sec_tens != 4'd0) begin
                            sec_tens <= sec_tens - 4'd1;
                        end else begin
                            sec_tens <= 4'd5;
                            if (min_ones != 4'd0) begin
                                min_ones <= min_ones - 4'd1;
                            end else begin
                                min_ones <= 4'd9;
                                min_tens <= min_tens - 4'd1;
                            end
                        end
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end else if (load) begin
                state    <= IDLE;
                presc    <= '0;
                min_tens <= clamp(init_min_tens, 4'd9);
                min_ones <= clamp(init_min_ones, 4'd9);
                sec_tens <= clamp(init_sec_tens, 4'd5);
                sec_ones <= clamp(init_sec_ones, 4'd9);
            end else if (start_stop) begin
                unique case (state)
                    IDLE: begin
                        presc <= '0;
                        if (is_zero) begin
                            state <= EXPIRED;
                            done  <= 1'b1;
                        end else begin
                            state <= RUNNING;
                        end
                    end
                    PAUSED:  state <= RUNNING;
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Sequential mm:ss BCD down-counter. It is the decrementing counterpart of the stopwatch's up-counting adder datapath.
- Loads a start time, decrements once per second while running, and flags expiry at 00:00.
- Sits beside the stopwatch core; its BCD digit outputs feed the same 7-segment display mux.
- Borrow logic is per-digit BCD, not binary subtraction.

Parameters:
TICKS_PER_SEC, 100000000, clk cycles per one-second decrement; must be >= 2; benches override it (e.g. 4).
CNT_W, $clog2(TICKS_PER_SEC), prescaler width (derived, not overridden).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high; one clock; all state cleared on the edge where it is high.
load  in  1  single-cycle strobe; captures init_* digits.
start_stop  in  1  single-cycle strobe; start, pause or resume.
init_min_tens  in  4  BCD minutes tens, 0-9.
init_min_ones  in  4  BCD minutes ones, 0-9.
init_sec_tens  in  4  BCD seconds tens, 0-5.
init_sec_ones  in  4  BCD seconds ones, 0-9.
min_tens, min_ones, sec_tens, sec_ones  out  4 each  current BCD count, registered.
running  out  1  high in RUNNING state.
done  out  1  one-cycle pulse on entry to EXPIRED.
expired  out  1  level; high in EXPIRED state.

Behaviour:
- Reset values: state IDLE, all digits 0, prescaler 0, running=0, done=0, expired=0.
- Reset mid-count aborts immediately; no done pulse is generated.
- States and transitions:
  - IDLE: start_stop with count != 00:00 -> RUNNING; start_stop with count == 00:00 -> EXPIRED.
  - RUNNING: start_stop -> PAUSED; count reaches 00:00 -> EXPIRED.
  - PAUSED: start_stop -> RUNNING.
  - EXPIRED: start_stop ignored; load -> IDLE.
- Load:
  - Accepted in IDLE, PAUSED and EXPIRED; ignored in RUNNING.
  - On acceptance: digits take the init_* values, prescaler clears to 0, state -> IDLE, expired clears.
  - Digit clamping at load: any digit > 9 loads as 9; init_sec_tens > 5 loads as 5.
- Simultaneous load and start_stop: load takes priority and start_stop is dropped, in the states where load is accepted. In RUNNING, load is ignored and start_stop acts (pause).
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1, only in RUNNING.
  - Frozen (value held) in PAUSED.
  - Cleared on load, on the IDLE->RUNNING transition, and on entry to EXPIRED.
  - Tick is asserted in the cycle where the prescaler == TICKS_PER_SEC-1 and state is RUNNING; the prescaler wraps to 0 on that edge.
- Decrement on tick (BCD borrow chain):
  - sec_ones 0 -> 9 with borrow, else -1.
  - On borrow: sec_tens 0 -> 5 with borrow, else -1.
  - On borrow: min_ones 0 -> 9 with borrow, else -1.
  - On borrow: min_tens -1.
  - min_tens never underflows, because 00:00 exits RUNNING first.
- Expiry:
  - When a tick takes the count to 00:00, state -> EXPIRED on that same edge.
  - Effects on that edge: running=0, expired=1, done=1 for exactly one cycle.
  - Digits hold 00:00 in EXPIRED.
- Latency:
  - First decrement lands TICKS_PER_SEC cycles after the edge that accepts start.
  - Subsequent decrements every TICKS_PER_SEC cycles.
  - Pause/resume preserves the partial second: the prescaler resumes from its held value.
- Outputs are registered; running, expired and done are derived from state registers only, no combinational path from inputs.
- Max count is 99:59.

Test Plan (TICKS_PER_SEC=4):
1. Reset, load 00:03, start -> 00:02, 00:01, 00:00 at 4, 8 and 12 cycles after start; done high exactly one cycle, coincident with the 00:00 edge; expired stays 1; running 0.
2. Load 10:00, start, one tick -> 09:59 (full borrow chain). Load 00:10 then one tick -> 00:09.
3. Load 00:05, start, pause after 2 cycles, idle 20 cycles, resume -> count holds 00:05 while paused; first decrement 2 cycles after resume.
4. Load 00:00 then start -> EXPIRED next edge with done pulse. Load 12:34 while EXPIRED -> IDLE, expired=0, digits 12:34.
5. Load with init_sec_tens=7 and init_sec_ones=12 -> digits show sec 59. Load and start_stop in the same cycle while IDLE -> state stays IDLE.
6. Assert reset while RUNNING at 01:30 -> next cycle all digits 0, running=0, no done pulse. Load ignored while RUNNING -> count continues unchanged.
